cgra_config_loader: RTL and testbench

Multi-chain, multi-context successor to the single-chain CGRA configurator. It reads configuration words from an external synchronous memory and serialises them onto NUM_CHAINS parallel configuration shift chains, one bit per chain per cycle. It supports selectable context, enable-based stalling, and a wipe mode that shifts all-zero configuration without memory reads. It sits between the configuration memory and the CGRA fabric's configuration scan chains.

---
 rtl/cgra_config_loader_if.sv | 51 +++++
 rtl/cgra_config_loader.sv | 92 +++++++++
 tb/tb_cgra_config_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/cgra_config_loader_if.sv
// Control, memory-read and chain-output signals of the CGRA configuration loader.
// The master modport is the loader side; the slave modport is the memory/fabric/control side.
interface cgra_config_loader_if #(
    parameter int unsigned NUM_CHAINS   = 4,
    parameter int unsigned CHAIN_LEN    = 128,
    parameter int unsigned NUM_CONTEXTS = 2
);
    localparam int unsigned ADDR_W = $clog2(NUM_CONTEXTS * CHAIN_LEN);
    localparam int unsigned CTX_W  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;

    logic                  start;
    // "context" is a reserved word in SystemVerilog, hence context_id.
    logic [CTX_W-1:0]      context_id;
    logic                  wipe;
    logic                  enable;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [NUM_CHAINS-1:0] rd_data;
    logic [NUM_CHAINS-1:0] bitstream;
    logic                  bitstream_valid;
    logic                  busy;
    logic                  done;

    modport master (
        input  start,
        input  context_id,
        input  wipe,
        input  enable,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output bitstream,
        output bitstream_valid,
        output busy,
        output done
    );

    modport slave (
        output start,
        output context_id,
        output wipe,
        output enable,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  bitstream,
        input  bitstream_valid,
        input  busy,
        input  done
    );
endinterface

// File: rtl/cgra_config_loader.sv
// Streams one configuration image from synchronous memory onto NUM_CHAINS parallel scan
// chains, one bit per chain per cycle, with enable stalling and an all-zero wipe mode.
module cgra_config_loader #(
    parameter int unsigned NUM_CHAINS   = 4,
    parameter int unsigned CHAIN_LEN    = 128,
    parameter int unsigned NUM_CONTEXTS = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    cgra_config_loader_if.master bus
);
    localparam int unsigned ADDR_W = $clog2(NUM_CONTEXTS * CHAIN_LEN);
    localparam int unsigned CTX_W  = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1;
    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wipe_q, wipe_d;
    logic                  valid_q;
    logic                  issue;
    logic                  start_ok;
    logic [CTX_W-1:0]      ctx_sel;
    logic [NUM_CHAINS-1:0] bits;

    assign ctx_sel  = bus.context_id;
    assign start_ok = bus.start && (32'(ctx_sel) < NUM_CONTEXTS);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        wipe_d  = wipe_q;
        issue   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    state_d = StLoad;
                    wipe_d  = bus.wipe;
                    count_d = '0;
                    addr_d  = ADDR_W'(CHAIN_LEN) * ADDR_W'(ctx_sel);
                end
            end
            StLoad: begin
                if (bus.enable) begin
                    issue = 1'b1;
                    // Address stops on the last word so it never crosses into the next image.
                    if (count_q == CNT_W'(CHAIN_LEN - 1)) begin
                        state_d = StDrain;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            wipe_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wipe_q  <= wipe_d;
            valid_q <= issue;
        end
    end

    // Memory data arrives one cycle after the read, exactly when valid_q marks the bit.
    assign bits = (valid_q && !wipe_q) ? bus.rd_data : '0;

    assign bus.rd_en           = issue && !wipe_q;
    assign bus.rd_addr         = addr_q;
    assign bus.bitstream       = bits;
    assign bus.bitstream_valid = valid_q;
    assign bus.busy            = (state_q == StLoad) || (state_q == StDrain);
    assign bus.done            = (state_q == StDone);
endmodule

// File: tb/tb_cgra_config_loader.sv
// Directed bench for cgra_config_loader with NUM_CHAINS=4, CHAIN_LEN=8, NUM_CONTEXTS=2,
// plus a NUM_CONTEXTS=3 instance where an out-of-range context can be expressed.
module tb_cgra_config_loader;
    localparam int unsigned CL = 8;

    logic clock = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    cgra_config_loader_if #(.NUM_CHAINS(4), .CHAIN_LEN(8), .NUM_CONTEXTS(2)) bus ();
    cgra_config_loader_if #(.NUM_CHAINS(4), .CHAIN_LEN(8), .NUM_CONTEXTS(3)) bus3 ();

    cgra_config_loader #(.NUM_CHAINS(4), .CHAIN_LEN(8), .NUM_CONTEXTS(2)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    cgra_config_loader #(.NUM_CHAINS(4), .CHAIN_LEN(8), .NUM_CONTEXTS(3)) u_dut3 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    // Synchronous memory holding memory[k] = k[3:0].
    always @(posedge clock) begin
        if (bus.rd_en) bus.rd_data <= bus.rd_addr;
    end
    assign bus3.rd_data = '0;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a load in the current cycle and follows it until done (bounded).
    // st1/st2: cycles after acceptance with enable=0; rs: cycle of an ignored start (ctx 0).
    task automatic do_load(input int ctx, input logic wp, input int st1, input int st2,
                           input int rs, input int exp_done);
        int   pulses     = 0;
        int   issues     = 0;
        logic issued     = 1'b0;
        logic seen_done  = 1'b0;
        logic exp_rd;
        bus.start      = 1'b1;
        bus.context_id = 1'(ctx);
        bus.wipe       = wp;
        bus.enable     = 1'b1;
        for (int c = 1; c <= 30 && !seen_done; c++) begin
            tick();
            bus.start      = (c == rs);
            bus.context_id = (c == rs) ? 1'b0 : 1'(ctx);
            bus.enable     = !(c == st1 || c == st2);
            #1;
            exp_rd = (issues < int'(CL)) && bus.enable && !wp;
            check("rd_en", 32'(bus.rd_en), 32'(exp_rd));
            check("valid", 32'(bus.bitstream_valid), 32'(issued));
            issued = (issues < int'(CL)) && bus.enable;
            if (issued) begin
                check("rd_addr", 32'(bus.rd_addr), 32'(ctx * int'(CL) + issues));
                issues++;
            end
            check("busy", 32'(bus.busy), 32'(c < exp_done));
            check("done", 32'(bus.done), 32'(c >= exp_done));
            if (bus.bitstream_valid) begin
                check("bits", 32'(bus.bitstream),
                      wp ? 32'd0 : 32'((ctx * int'(CL) + pulses) % 16));
                pulses++;
            end else begin
                check("bits_idle", 32'(bus.bitstream), 32'd0);
            end
            seen_done = bus.done;
        end
        check("pulses", 32'(pulses), 32'(CL));
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.context_id  = '0;
        bus.wipe        = 1'b0;
        bus.enable      = 1'b0;
        bus3.start      = 1'b0;
        bus3.context_id = '0;
        bus3.wipe       = 1'b0;
        bus3.enable     = 1'b0;
        #1;
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_valid", 32'(bus.bitstream_valid), 32'd0);
        check("rst_bits", 32'(bus.bitstream), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Context 1, no stall, from IDLE; then back-to-back start in the done cycle.
        do_load(1, 1'b0, 0, 0, 0, 10);
        do_load(1, 1'b0, 0, 0, 0, 10);
        tick();

        // Context 0 with enable low in cycles t+3 and t+6.
        do_load(0, 1'b0, 3, 6, 0, 12);
        tick();

        // Wipe of context 1.
        do_load(1, 1'b1, 0, 0, 0, 10);
        tick();

        // start with context 0 mid-load is ignored.
        do_load(1, 1'b0, 0, 0, 4, 10);
        tick();

        // Out-of-range context rejected; an in-range one then accepted.
        bus3.enable     = 1'b1;
        bus3.context_id = 2'd3;
        bus3.start      = 1'b1;
        tick();
        bus3.start = 1'b0;
        #1;
        check("rej_busy", 32'(bus3.busy), 32'd0);
        check("rej_rd_en", 32'(bus3.rd_en), 32'd0);
        check("rej_addr", 32'(bus3.rd_addr), 32'd0);
        tick();
        check("rej_busy2", 32'(bus3.busy), 32'd0);
        bus3.context_id = 2'd2;
        bus3.start      = 1'b1;
        tick();
        bus3.start = 1'b0;
        #1;
        check("acc_busy", 32'(bus3.busy), 32'd1);
        check("acc_rd_en", 32'(bus3.rd_en), 32'd1);
        check("acc_addr", 32'(bus3.rd_addr), 32'd16);

        // Reset asserted in cycle t+5 of a load clears outputs before the next edge.
        bus.start      = 1'b1;
        bus.context_id = 1'b0;
        bus.wipe       = 1'b0;
        bus.enable     = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #1;
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        check("pre_rst_addr", 32'(bus.rd_addr), 32'd4);
        reset_n = 1'b0;
        #1;
        check("arst_rd_en", 32'(bus.rd_en), 32'd0);
        check("arst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("arst_valid", 32'(bus.bitstream_valid), 32'd0);
        check("arst_bits", 32'(bus.bitstream), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        do_load(0, 1'b0, 0, 0, 0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
